mem_arb: RTL
============

# mem_arb

Single-port memory arbiter for the SISC computer. The instruction-fetch path (IR load) and the data path (LOD/STR) share one unified memory. This block grants the port to one requester at a time, holds the address, data and write-enable stable for a fixed number of wait cycles, returns read data, and signals completion. It sits between the control FSM/datapath requesters and the memory array.

## Interface
- ADDR_W, 16, address width
- DATA_W, 32, data width
- MEM_LAT, 2, memory access cycles; legal range 1..7
- clk  in  1  system clock, rising edge
- rst_f  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  ADDR_W  fetch address (PC)
- if_gnt  out  1  one-cycle grant pulse to fetch
- if_done  out  1  one-cycle completion pulse; rdata valid
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store (STR), 0 = load (LOD)
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  one-cycle grant pulse to data
- d_done  out  1  one-cycle completion pulse
- rdata  out  DATA_W  read data register, shared by both requesters
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  high in ACCESS and DONE

## Operation
- States: IDLE, ACCESS, DONE. Register `owner` (0 = fetch, 1 = data). Register `cnt` (3 bits).
- IDLE: sample the requests at the clock edge. If any is high, pick a winner by priority (see Configuration). At that edge, latch the winner's addr, the wdata and the we into the mem_* registers. Set owner. Load cnt = MEM_LAT-1. Go to ACCESS. With no request, stay in IDLE.
- ACCESS: mem_en = 1. mem_addr, mem_we and mem_wdata are stable for all MEM_LAT cycles. The grant pulse for the owner is asserted in the first ACCESS cycle only. cnt decrements each cycle.
  - When cnt == 0: if mem_we = 0, capture mem_rdata into rdata. Go to DONE.
- DONE: mem_en = 0. The done pulse for the owner is asserted for one cycle. Always go to IDLE.
- Writes leave rdata unchanged. Fetch fetches are always reads: mem_we = 0.
- The loser of a tie keeps its request held and is served in the next arbitration.
- A request still high in DONE is treated as a new request at the following IDLE edge. Requesters must drop req after gnt to avoid a duplicate access.
- Inputs of the requester that is not the owner are ignored during ACCESS and DONE.

## Timing
- Reset values: all outputs 0. rdata = 0. State = IDLE. owner = 0. Round-robin pointer = data-last.
- Asserting rst_f low at any time forces IDLE immediately and drops mem_en asynchronously. An in-flight access is abandoned and no done pulse is issued.
- Request sampled high at edge E0, then:
  - gnt and mem_en are high in cycle E0..E1.
  - mem_en stays high for MEM_LAT cycles.
  - done is high in the cycle after the last ACCESS cycle, with rdata valid in the same cycle.
- Latency from sampling edge to done = MEM_LAT+1 cycles.
- Minimum spacing between two sampling edges = MEM_LAT+2 cycles, because one IDLE cycle is mandatory.
- With MEM_LAT = 1: gnt and the single ACCESS cycle coincide, and done is one cycle later.
- mem_addr and mem_wdata hold their last value in IDLE and DONE. mem_we is cleared in DONE.

## Configuration
- MEM_ARB_RR_EN defined: round-robin on ties. The requester not served last wins. After reset, fetch wins the first tie.
- MEM_ARB_RR_EN undefined: fixed priority. Data always wins ties, so an executing LOD/STR completes before the next fetch. No pointer register is built.

## Test plan
- MEM_LAT=2, if_req with if_addr=0x0010 and mem_rdata=0xDEADBEEF:
  - if_gnt pulses in cycle 1.
  - mem_en is high in cycles 1–2.
  - if_done is high in cycle 3 with rdata=0xDEADBEEF.
- d_req with d_we=1, d_addr=0x0020, d_wdata=0x12345678:
  - mem_we=1 and mem_addr/mem_wdata are held for 2 cycles.
  - d_done pulses.
  - rdata is unchanged.
- Fixed priority, if_req and d_req rise together:
  - data is served first.
  - fetch is served second, with exactly one IDLE cycle between d_done and the start of the fetch ACCESS.
- MEM_ARB_RR_EN, both requests held continuously for 4 accesses: grant order is fetch, data, fetch, data.
- rst_f pulled low in the second ACCESS cycle:
  - mem_en drops immediately.
  - no done pulse is issued.
  - after release, a new request completes normally.
- MEM_LAT=1 and MEM_LAT=7: done arrives exactly 2 and 8 cycles after the sampling edge.

Source files
------------

// File: rtl/mem_arb.sv
// Single-port memory arbiter for the SISC fetch and data paths.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_RR_EN.
module mem_arb #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              rst_f,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_done,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t            state, state_nxt;
  logic              owner, owner_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [DATA_W-1:0] wdata_q, wdata_nxt;
  logic              we_q, we_nxt;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;
  logic              any_req;
  logic              pick_data;

  assign any_req = if_req | d_req;

`ifdef MEM_ARB_RR_EN
  // last_data = 1 means data was served most recently, so fetch wins the next tie.
  logic last_data;

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f)
      last_data <= 1'b1;
    else if (state == IDLE && any_req)
      last_data <= pick_data;
  end

  always_comb begin
    pick_data = d_req;
    if (if_req && d_req)
      pick_data = ~last_data;
  end
`else
  // Data always wins so an executing LOD/STR finishes before the next fetch.
  always_comb begin
    pick_data = d_req;
  end
`endif

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state   <= IDLE;
      owner   <= 1'b0;
      cnt     <= 3'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      cnt     <= cnt_nxt;
      addr_q  <= addr_nxt;
      wdata_q <= wdata_nxt;
      we_q    <= we_nxt;
      rdata_q <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    cnt_nxt   = cnt;
    addr_nxt  = addr_q;
    wdata_nxt = wdata_q;
    we_nxt    = we_q;
    rdata_nxt = rdata_q;
    unique case (state)
      IDLE: begin
        if (any_req) begin
          state_nxt = ACCESS;
          owner_nxt = pick_data;
          cnt_nxt   = CNT_INIT;
          if (pick_data) begin
            addr_nxt  = d_addr;
            wdata_nxt = d_wdata;
            we_nxt    = d_we;
          end else begin
            addr_nxt  = if_addr;
            we_nxt    = 1'b0;
          end
        end
      end
      ACCESS: begin
        cnt_nxt = cnt - 3'd1;
        // The last access cycle: memory data is valid, write enable drops with DONE.
        if (cnt == 3'd0) begin
          state_nxt = DONE;
          we_nxt    = 1'b0;
          if (!we_q)
            rdata_nxt = mem_rdata;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Grant marks the first access cycle, identified by the freshly loaded counter.
  assign if_gnt    = (state == ACCESS) && (cnt == CNT_INIT) && !owner;
  assign d_gnt     = (state == ACCESS) && (cnt == CNT_INIT) && owner;
  assign if_done   = (state == DONE) && !owner;
  assign d_done    = (state == DONE) && owner;
  assign mem_en    = (state == ACCESS);
  assign busy      = (state != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule
